// File: rtl/fp_add_if.sv
// fp_add_if: operand/result valid-ready bundle for the pipelined FP adder
interface fp_add_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;
  logic in_valid, in_ready, op_sub, out_valid, out_ready, ovf, invalid;
  logic [W-1:0] a, b, result;
  modport master (output in_valid, a, b, op_sub, out_ready, input in_ready, out_valid, result, ovf, invalid);
  modport slave (input in_valid, a, b, op_sub, out_ready, output in_ready, out_valid, result, ovf, invalid);
endinterface

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined FP adder/subtractor, flush-to-zero, truncating, global stall
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst,
  fp_add_if.slave io
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 3;
  localparam int NW = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int LZ_W = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] E_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  logic en, v1, v2, v3;
  logic sa, sb, a_big, nan_a, nan_b, inf_a, inf_b;
  logic [EXP_W-1:0] ea, eb, ex, ey, d;
  logic [MAN_W-1:0] ma, mb;
  logic [SW-1:0] gx, gy;
  logic sx1, sub1, nan1, inf1, isg1;
  logic [EXP_W-1:0] ex1;
  logic [SW-1:0] gx1, gy1;
  logic sx2, nan2, inf2, isg2;
  logic [EXP_W-1:0] ex2;
  logic [NW-1:0] sum2;
  logic [LZ_W-1:0] lz;
  logic [SW-1:0] norm;
  logic [EW-1:0] e;
  logic [MAN_W-1:0] mn;
  logic of, uf, ovf_n;
  logic [W-1:0] res, res3;
  logic ovf3, inv3;
  logic unused_bits;
  assign en = !v3 || io.out_ready;
  assign io.in_ready = en;
  assign io.out_valid = v3;
  assign io.result = res3;
  assign io.ovf = v3 && ovf3;
  assign io.invalid = v3 && inv3;
  assign sa = io.a[W-1];
  assign sb = io.b[W-1] ^ io.op_sub;
  assign ea = io.a[W-2:MAN_W];
  assign eb = io.b[W-2:MAN_W];
  assign ma = io.a[MAN_W-1:0];
  assign mb = io.b[MAN_W-1:0];
  assign nan_a = &ea && |ma;
  assign nan_b = &eb && |mb;
  assign inf_a = &ea && ~|ma;
  assign inf_b = &eb && ~|mb;
  assign a_big = {ea, ma} >= {eb, mb};
  assign ex = a_big ? ea : eb;
  assign ey = a_big ? eb : ea;
  assign d = ex - ey;
  assign gx = ex == '0 ? '0 : {1'b1, a_big ? ma : mb, 2'b00};
  assign gy = ey == '0 || 32'(d) >= SW ? '0 : {1'b1, a_big ? mb : ma, 2'b00} >> d;
  always_comb begin
    lz = '0;
    for (int i = 0; i < SW; i++) lz = sum2[i] ? LZ_W'(SW - 1 - i) : lz;
    norm = sum2[SW-1:0] << lz;
    e = sum2[SW] ? EW'(ex2) + EW'(1) : EW'(ex2) - EW'(lz);
    mn = sum2[SW] ? sum2[SW-1:3] : norm[SW-2:2];
    of = !e[EW-1] && e[EW-2:0] >= (EW-1)'(E_ONES);
    uf = e[EW-1] || e == '0;
    ovf_n = of && !nan2 && !inf2 && |sum2;
    res = nan2 ? QNAN : inf2 ? {isg2, E_ONES, {MAN_W{1'b0}}} : sum2 == '0 ? '0 :
          of ? {sx2, E_ONES, {MAN_W{1'b0}}} : uf ? {sx2, {(W-1){1'b0}}} : {sx2, e[EXP_W-1:0], mn};
  end
  assign unused_bits = ^{norm[SW-1], norm[1:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      res3 <= '0;
      ovf3 <= 1'b0;
      inv3 <= 1'b0;
    end else if (en) begin
      v1 <= io.in_valid;
      v2 <= v1;
      v3 <= v2;
      sx1 <= a_big ? sa : sb;
      sub1 <= sa ^ sb;
      ex1 <= ex;
      gx1 <= gx;
      gy1 <= gy;
      nan1 <= nan_a || nan_b || (inf_a && inf_b && sa != sb);
      inf1 <= inf_a || inf_b;
      isg1 <= inf_a ? sa : sb;
      sx2 <= sx1;
      ex2 <= ex1;
      nan2 <= nan1;
      inf2 <= inf1;
      isg2 <= isg1;
      sum2 <= sub1 ? {1'b0, gx1} - {1'b0, gy1} : {1'b0, gx1} + {1'b0, gy1};
      res3 <= res;
      ovf3 <= ovf_n;
      inv3 <= nan2;
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: randomized scoreboard bench for fp_add_pipe against a rule-level reference model
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int bp_mode = 0;
  logic [33:0] exp_q[$];
  logic [31:0] ra, rb;
  logic rop;
  logic [98:0] v;
  localparam logic [98:0] VEC [14] = '{
    {32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 2'b00},
    {32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 2'b00},
    {32'h3FC00000, 32'hBFC00000, 1'b0, 32'h00000000, 2'b00},
    {32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b10},
    {32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2'b01},
    {32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 2'b00},
    {32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 2'b00},
    {32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 2'b00},
    {32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 2'b00},
    {32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 2'b00},
    {32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2'b01},
    {32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 2'b00},
    {32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2'b01},
    {32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 2'b00}
  };
  fp_add_if ifc();
  fp_add_pipe dut(.clk(clk), .rst(rst), .io(ifc));
  always #5 clk = ~clk;
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic sa, sb, sx, sy;
    int ea, eb, ex, ey, e, d;
    longint ma, mb, gx, gy, mx, my, s;
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0) || (ea == 255 && eb == 255 && sa != sb))
      return {32'h7FC00000, 2'b01};
    if (ea == 255) return {sa, 8'hFF, 23'd0, 2'b00};
    if (eb == 255) return {sb, 8'hFF, 23'd0, 2'b00};
    gx = ea == 0 ? 0 : (ma + (longint'(1) << 23)) * 4;
    gy = eb == 0 ? 0 : (mb + (longint'(1) << 23)) * 4;
    if (a[30:0] >= b[30:0]) begin
      sx = sa; sy = sb; ex = ea; ey = eb; mx = gx; my = gy;
    end else begin
      sx = sb; sy = sa; ex = eb; ey = ea; mx = gy; my = gx;
    end
    d = ex - ey;
    my = d >= 26 ? 0 : my >> d;
    s = sx == sy ? mx + my : mx - my;
    if (s == 0) return 34'd0;
    e = ex;
    while (s >= (longint'(1) << 26)) begin s = s / 2; e++; end
    while (s < (longint'(1) << 25)) begin s = s * 2; e--; end
    if (e >= 255) return {sx, 8'hFF, 23'd0, 2'b10};
    if (e <= 0) return {sx, 31'd0, 2'b00};
    return {sx, e[7:0], s[24:2], 2'b00};
  endfunction
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [33:0] e);
    int n = 0;
    ifc.a = a;
    ifc.b = b;
    ifc.op_sub = sub;
    ifc.in_valid = 1'b1;
    @(negedge clk);
    while (!ifc.in_ready && n < 200) begin @(negedge clk); n++; end
    check("accept_within_bound", 64'(ifc.in_ready), 64'd1);
    if (ifc.in_ready) exp_q.push_back(e);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      ifc.out_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else if (ifc.out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_output result=%h required no output", ifc.result);
      end else begin
        if ({ifc.result, ifc.ovf, ifc.invalid} !== exp_q[0]) begin
          errors++;
          $display("FAIL result got=%h ovf=%b invalid=%b required=%h ovf=%b invalid=%b",
                   ifc.result, ifc.ovf, ifc.invalid, exp_q[0][33:2], exp_q[0][1], exp_q[0][0]);
        end
        if (ifc.out_ready) void'(exp_q.pop_front());
      end
    end else begin
      checks++;
      if (ifc.ovf || ifc.invalid) begin
        errors++;
        $display("FAIL idle_flags ovf=%b invalid=%b required 0 0", ifc.ovf, ifc.invalid);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    ifc.in_valid = 1'b0;
    ifc.a = '0;
    ifc.b = '0;
    ifc.op_sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'({ifc.out_valid, ifc.result, ifc.ovf, ifc.invalid}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 64'(ifc.in_ready), 64'd1);
    @(posedge clk); #1;
    issue(32'h3F800000, 32'h3F800000, 1'b0, {32'h40000000, 2'b00});
    @(posedge clk); #1;
    check("latency_not_yet", 64'(ifc.out_valid), 64'd0);
    @(posedge clk); #1;
    check("latency_three_edges", 64'(ifc.out_valid), 64'd1);
    drain();
    for (int i = 0; i < 14; i++) begin
      v = VEC[i];
      issue(v[98:67], v[66:35], v[34], v[33:0]);
    end
    drain();
    bp_mode = 1;
    fork
      for (int i = 0; i < 4; i++) begin
        ra = $urandom;
        rb = {$urandom_range(0, 1) == 1, ra[30:23], 23'($urandom)};
        rop = 1'($urandom_range(0, 1));
        issue(ra, rb, rop, model(ra, rb, rop));
      end
      begin : stall_watch
        int n;
        n = 0;
        while (!ifc.out_valid && n < 50) begin @(negedge clk); n++; end
        check("stall_output_seen", 64'(ifc.out_valid), 64'd1);
        repeat (5) begin
          check("stall_in_ready_low", 64'({ifc.in_ready, ifc.out_ready}), 64'd0);
          @(negedge clk);
        end
        bp_mode = 0;
      end
    join
    drain();
    issue(32'h3F800000, 32'h40000000, 1'b0, {32'h40400000, 2'b00});
    issue(32'h40000000, 32'h40000000, 1'b0, {32'h40800000, 2'b00});
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_flush_out_valid", 64'(ifc.out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("reset_nothing_emitted", 64'(ifc.out_valid), 64'd0);
    bp_mode = 2;
    for (int i = 0; i < 400; i++) begin
      int kind;
      ra = $urandom;
      rb = $urandom;
      rop = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 7);
      if (kind <= 3) rb[30:23] = ra[30:23] ^ 8'($urandom_range(0, 7));
      else if (kind == 4) ra[30:0] = rb[30:0];
      else if (kind == 5) begin
        ra[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 1) ra[22:0] = '0;
      end else if (kind == 6) begin
        ra[30:23] = 8'($urandom_range(0, 3));
        rb[30:23] = 8'($urandom_range(0, 3));
      end
      issue(ra, rb, rop, model(ra, rb, rop));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
